fa_response_checker: RTL and testbench

Synthesizable response checker for the full-adder test environment. It is the receiving end of the stimulus stream that drives a/b/cin into a Fulladder. It samples each applied vector together with the DUT's sum/cout, compares them against a golden add, and tracks which input vectors have been covered. It raises done/pass once every input combination has been seen, so on-board and simulation runs of the adder are self-checking.

---
 rtl/fa_chk_pkg.sv | 11 +
 rtl/fa_ref_model.sv | 14 +
 rtl/fa_response_checker.sv | 79 +++++++
 tb/tb_fa_response_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fa_chk_pkg.sv
// fa_chk_pkg: shared types and sizing helpers for the full-adder response checkers
package fa_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // Coverage index is {a,b,cin}
  function automatic int cov_idx_w(input int width);
    return 2 * width + 1;
  endfunction
  function automatic int num_vec(input int width);
    return 2 ** (2 * width + 1);
  endfunction
endpackage

// File: rtl/fa_ref_model.sv
// fa_ref_model: golden adder, expected = {cout,sum} = a + b + cin
//   a, b     : operands
//   cin      : carry-in
//   expected : {cout,sum}, WIDTH+1 bits
module fa_ref_model #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   expected
);
  assign expected = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
endmodule

// File: rtl/fa_response_checker.sv
// fa_response_checker: checks adder responses against a golden add and tracks input coverage
//   start              : clear all state and begin a run
//   in_valid,a,b,cin   : applied vector (accepted only in RUN without start)
//   sum,cout           : DUT response
//   mismatch           : pulse, previous accepted sample failed
//   err_cnt,vec_cnt    : saturating failure / sample counters
//   first_fail         : {a,b,cin} of first failing sample
//   done,pass          : full coverage reached / reached with no errors
module fa_response_checker
  import fa_chk_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic [WIDTH-1:0]   sum,
  input  logic               cout,
  output logic               mismatch,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   vec_cnt,
  output logic [2*WIDTH:0]   first_fail,
  output logic               done,
  output logic               pass
);
  localparam int IW = cov_idx_w(WIDTH);
  localparam int NV = num_vec(WIDTH);
  state_t state, state_n;
  logic [NV-1:0] cov, cov_set;
  logic [IW-1:0] idx;
  logic [WIDTH:0] expected;
  logic accept, fail;
  fa_ref_model #(.WIDTH(WIDTH)) u_ref (.a(a), .b(b), .cin(cin), .expected(expected));
  assign idx = {a, b, cin};
  assign accept = state == RUN && in_valid && !start;
  assign fail = {cout, sum} != expected;
  always_comb begin
    cov_set = cov;
    cov_set[idx] = 1'b1;
  end
  // The covering sample moves to DONE on the same edge its error (if any) is counted
  assign state_n = start ? RUN : (accept && &cov_set) ? DONE : state;
  assign done = state == DONE;
  assign pass = done && err_cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cov <= '0;
      mismatch <= 1'b0;
      err_cnt <= '0;
      vec_cnt <= '0;
      first_fail <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        cov <= '0;
        mismatch <= 1'b0;
        err_cnt <= '0;
        vec_cnt <= '0;
        first_fail <= '0;
      end else begin
        mismatch <= accept && fail;
        if (accept) begin
          cov <= cov_set;
          vec_cnt <= &vec_cnt ? vec_cnt : vec_cnt + CNT_W'(1);
          if (fail) begin
            err_cnt <= &err_cnt ? err_cnt : err_cnt + CNT_W'(1);
            if (err_cnt == '0) first_fail <= idx;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fa_response_checker.sv
// tb_fa_response_checker: randomized self-checking bench, two checker instances (16-bit and 3-bit counters)
module tb_fa_response_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, cin = 1'b0, sum = 1'b0, cout = 1'b0;
  logic mis_a, mis_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] err_a, vec_a;
  logic [2:0] err_b, vec_b, ff_a, ff_b;
  logic [37:0] obs_a;
  logic [11:0] obs_b;
  int n_chk = 0, n_fail = 0;
  bit m_run, m_done, m_mis;
  int m_vec, m_err;
  logic [2:0] m_ff;
  bit m_cov [8];

  always #5 clk = ~clk;

  fa_response_checker #(.WIDTH(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .mismatch(mis_a), .err_cnt(err_a), .vec_cnt(vec_a),
    .first_fail(ff_a), .done(done_a), .pass(pass_a));
  fa_response_checker #(.WIDTH(1), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .mismatch(mis_b), .err_cnt(err_b), .vec_cnt(vec_b),
    .first_fail(ff_b), .done(done_b), .pass(pass_b));

  assign obs_a = {mis_a, err_a, vec_a, ff_a, done_a, pass_a};
  assign obs_b = {mis_b, err_b, vec_b, ff_b, done_b, pass_b};

  function automatic int sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return v > lim ? lim : v;
  endfunction

  function automatic logic [37:0] exp_a();
    return {m_mis, 16'(sat(m_err, 16)), 16'(sat(m_vec, 16)), m_ff, m_done, m_done && m_err == 0};
  endfunction

  function automatic logic [11:0] exp_b();
    return {m_mis, 3'(sat(m_err, 3)), 3'(sat(m_vec, 3)), m_ff, m_done, m_done && m_err == 0};
  endfunction

  task automatic mdl_clear();
    m_run = 0; m_done = 0; m_mis = 0; m_vec = 0; m_err = 0; m_ff = '0;
    foreach (m_cov[i]) m_cov[i] = 0;
  endtask

  // Reference behaviour at a clock edge, from the current inputs
  task automatic mdl_edge();
    bit all;
    if (start) begin
      mdl_clear();
      m_run = 1;
    end else begin
      m_mis = 0;
      if (m_run && !m_done && in_valid) begin
        m_vec++;
        m_cov[{a, b, cin}] = 1;
        if (int'({cout, sum}) != int'(a) + int'(b) + int'(cin)) begin
          m_mis = 1;
          if (m_err == 0) m_ff = {a, b, cin};
          m_err++;
        end
        all = 1;
        foreach (m_cov[i]) all &= m_cov[i];
        if (all) m_done = 1;
      end
    end
  endtask

  // Drive one cycle of stimulus; bad inverts the DUT sum. Returns at posedge+1.
  task automatic step(input bit st, input bit v, input logic [2:0] vec, input bit bad);
    start = st; in_valid = v; {a, b, cin} = vec;
    {cout, sum} = 2'(int'(vec[2]) + int'(vec[1]) + int'(vec[0]));
    sum = sum ^ bad;
    @(posedge clk);
    mdl_edge();
    #1;
    start = 0; in_valid = 0;
  endtask

  task automatic shuffle(output int p [8]);
    int j, t;
    foreach (p[i]) p[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_fail++;
      $display("FAIL reset: got a=%h b=%h, want 0", obs_a, obs_b);
    end
    rst_n = 1;
    step(0, 1, 3'b011, 0);
    n_chk++;
    if (obs_a !== '0) begin
      n_fail++;
      $display("FAIL idle_ignore: got %h, want 0", obs_a);
    end
  endtask

  task automatic test_exhaustive();
    int p [8];
    shuffle(p);
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3'(p[i]), 0);
      n_chk++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        n_fail++;
        $display("FAIL exhaustive[%0d]: got a=%h b=%h, want a=%h b=%h", i, obs_a, obs_b, exp_a(), exp_b());
      end
    end
    n_chk++;
    if (!(done_a === 1 && pass_a === 1 && err_a === 0 && vec_a === 8 && mis_a === 0)) begin
      n_fail++;
      $display("FAIL exhaustive_end: got done=%b pass=%b err=%0d vec=%0d, want 1 1 0 8", done_a, pass_a, err_a, vec_a);
    end
    step(0, 1, 3'b111, 1);
    n_chk++;
    if (vec_a !== 8 || mis_a !== 0 || done_a !== 1) begin
      n_fail++;
      $display("FAIL done_ignore: got vec=%0d mis=%b done=%b, want 8 0 1", vec_a, mis_a, done_a);
    end
  endtask

  task automatic test_fault();
    int p [8];
    int pulses = 0;
    shuffle(p);
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3'(p[i]), p[i] == 5);
      pulses += int'(mis_a);
      n_chk++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        n_fail++;
        $display("FAIL fault[%0d]: got a=%h b=%h, want a=%h b=%h", i, obs_a, obs_b, exp_a(), exp_b());
      end
    end
    n_chk++;
    if (!(pulses == 1 && err_a === 1 && ff_a === 3'b101 && done_a === 1 && pass_a === 0)) begin
      n_fail++;
      $display("FAIL fault_end: got pulses=%0d err=%0d ff=%b done=%b pass=%b, want 1 1 101 1 0",
               pulses, err_a, ff_a, done_a, pass_a);
    end
  endtask

  task automatic test_partial();
    step(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 3'($urandom_range(3, 0)), 0);
    n_chk++;
    if (obs_a !== exp_a() || vec_a !== 16 || done_a !== 0 || pass_a !== 0 || vec_b !== 7) begin
      n_fail++;
      $display("FAIL partial: got vec=%0d done=%b pass=%b vec_b=%0d, want 16 0 0 7", vec_a, done_a, pass_a, vec_b);
    end
    step(0, 1, 3'b100, 0);
    n_chk++;
    if (vec_a !== 17) begin
      n_fail++;
      $display("FAIL partial_run: got vec=%0d, want 17", vec_a);
    end
  endtask

  task automatic test_midrun_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 3'(i), i == 2);
    n_chk++;
    if (obs_a !== exp_a() || err_a !== 1 || vec_a !== 5) begin
      n_fail++;
      $display("FAIL pre_reset: got %h, want %h", obs_a, exp_a());
    end
    rst_n = 0;
    mdl_clear();
    #1;
    n_chk++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got a=%h b=%h, want 0", obs_a, obs_b);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) step(0, 1, 3'(i + 5), 1);
    n_chk++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_fail++;
      $display("FAIL post_reset_ignore: got a=%h b=%h, want 0", obs_a, obs_b);
    end
  endtask

  task automatic test_start_coincident();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'(i), i == 1);
    step(1, 1, 3'b111, 1);
    n_chk++;
    if (obs_a !== exp_a() || vec_a !== 0 || err_a !== 0 || mis_a !== 0) begin
      n_fail++;
      $display("FAIL start_drop: got vec=%0d err=%0d mis=%b, want 0 0 0", vec_a, err_a, mis_a);
    end
    step(0, 1, 3'b110, 0);
    n_chk++;
    if (vec_a !== 1 || obs_a !== exp_a()) begin
      n_fail++;
      $display("FAIL start_resume: got vec=%0d, want 1", vec_a);
    end
  endtask

  task automatic test_saturation();
    int p [8];
    shuffle(p);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, i < 8 ? 3'(p[i]) : 3'($urandom_range(7, 0)), 1);
      n_chk++;
      if (obs_b !== exp_b()) begin
        n_fail++;
        $display("FAIL sat[%0d]: got %h, want %h", i, obs_b, exp_b());
      end
    end
    n_chk++;
    if (!(vec_b === 7 && err_b === 7 && done_b === 1 && pass_b === 0 && vec_a === 8 && err_a === 8
          && ff_b === 3'(p[0]))) begin
      n_fail++;
      $display("FAIL sat_end: got vec_b=%0d err_b=%0d done=%b pass=%b vec_a=%0d err_a=%0d ff=%b, want 7 7 1 0 8 8 %b",
               vec_b, err_b, done_b, pass_b, vec_a, err_a, ff_b, 3'(p[0]));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(24, 0) == 0, $urandom_range(3, 0) != 0, 3'($urandom_range(7, 0)),
           $urandom_range(7, 0) == 0);
      n_chk++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        n_fail++;
        $display("FAIL random[%0d]: got a=%h b=%h, want a=%h b=%h", i, obs_a, obs_b, exp_a(), exp_b());
      end
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_fault();
    test_partial();
    test_midrun_reset();
    test_start_coincident();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
